// File: rtl/fetch_pc_ctrl_if.sv
// ----------------------------------------------------------------------------
// fetch_pc_ctrl_if
// Bus between the fetch PC sequencer and the fetch/decode logic.
//   f_pc     fetch address chosen this cycle (sequencer -> fetch)
//   f_valid  f_pc is a real fetch; low means inject a bubble
//   f_icode  icode of the instruction fetched at f_pc (fetch -> sequencer)
//   f_valC   constant word of the fetched instruction
//   f_valP   fall-through address of the fetched instruction
//   f_halt   fetched instruction is halt, invalid, or hit an imem error
// Modports: master = PC sequencer, slave = fetch stage.
// ----------------------------------------------------------------------------
interface fetch_pc_ctrl_if #(
   parameter int ADDR_W = 64
);
   logic [ADDR_W-1:0] f_pc;
   logic              f_valid;
   logic [3:0]        f_icode;
   logic [ADDR_W-1:0] f_valC;
   logic [ADDR_W-1:0] f_valP;
   logic              f_halt;

   modport master (
      output f_pc, f_valid,
      input  f_icode, f_valC, f_valP, f_halt
   );

   modport slave (
      input  f_pc, f_valid,
      output f_icode, f_valC, f_valP, f_halt
   );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_pc_ctrl
// Fetch-side PC sequencer for the pipelined Y86-64 core. Holds the F pipeline
// register (predicted PC), picks the fetch PC from the misprediction, return
// and predicted paths, and predicts the next PC from the fetched instruction.
// Fetching stops while a ret resolves and after halt/invalid.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   F_stall           hold the F register; no new fetch consumed
//   fbus (master)     f_pc/f_valid out; f_icode/f_valC/f_valP/f_halt in
//   M_icode/M_cnd     instruction and branch outcome in Memory stage
//   M_valA            fall-through PC carried by a jXX in M
//   W_icode/W_valM    instruction and popped return address in Write-back
//   F_predPC          registered predicted PC
//   fsm_state         00 RUN, 01 RET_WAIT, 10 HALTED
// ----------------------------------------------------------------------------
module fetch_pc_ctrl #(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                F_stall,
   fetch_pc_ctrl_if.master     fbus,
   input  logic [3:0]          M_icode,
   input  logic                M_cnd,
   input  logic [ADDR_W-1:0]   M_valA,
   input  logic [3:0]          W_icode,
   input  logic [ADDR_W-1:0]   W_valM,
   output logic [ADDR_W-1:0]   F_predPC,
   output logic [1:0]          fsm_state
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_RET_WAIT = 2'b01,
      ST_HALTED   = 2'b10,
      ST_UNUSED   = 2'b11   // never entered; behaves as HALTED
   } state_t;

   localparam logic [3:0] I_JXX  = 4'h7;
   localparam logic [3:0] I_CALL = 4'h8;
   localparam logic [3:0] I_RET  = 4'h9;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pred_q, pred_d;
   logic [ADDR_W-1:0] pred_next;
   logic              mispred, retdone;
   logic              in_ret_wait, in_halted;

   // Redirect sources and fetch PC selection (all same-cycle).
   always_comb begin
      mispred     = (M_icode == I_JXX) && !M_cnd;
      retdone     = (W_icode == I_RET);
      in_ret_wait = (state_q == ST_RET_WAIT);
      in_halted   = (state_q == ST_HALTED) || (state_q == ST_UNUSED);

      // A mispredicted jXX in M is the live redirect and beats a ret in W.
      if (mispred)
         fbus.f_pc = M_valA;
      else if (retdone && in_ret_wait)
         fbus.f_pc = W_valM;
      else
         fbus.f_pc = pred_q;

      if (in_halted)
         fbus.f_valid = mispred;
      else if (in_ret_wait)
         fbus.f_valid = retdone | mispred;
      else
         fbus.f_valid = 1'b1;

      if ((fbus.f_icode == I_JXX) || (fbus.f_icode == I_CALL))
         pred_next = fbus.f_valC;
      else
         pred_next = fbus.f_valP;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; otherwise
      // the hold cases would infer latches.
      pred_d  = pred_q;
      state_d = state_q;

      if (F_stall) begin
         // Reloading with f_pc holds normally, and keeps a redirect that
         // arrives during a stall from being lost.
         pred_d = fbus.f_pc;
         if (mispred || (retdone && in_ret_wait))
            state_d = ST_RUN;
      end else if (fbus.f_valid) begin
         pred_d = pred_next;
         if (fbus.f_halt)
            state_d = ST_HALTED;
         else if (fbus.f_icode == I_RET)
            state_d = ST_RET_WAIT;
         else
            state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      if (!rst_n) begin
         pred_q  <= RESET_PC;
         state_q <= ST_RUN;
      end else begin
         pred_q  <= pred_d;
         state_q <= state_d;
      end
   end

   assign F_predPC  = pred_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_ctrl
// Scoreboard bench for fetch_pc_ctrl. The driver applies one cycle of
// stimulus, asks a behavioural model what the DUT must show this cycle, and
// queues that expectation; a separate monitor pops and compares on the
// falling edge. Directed scenarios come first, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

   localparam int ADDR_W = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              F_stall;
   logic [3:0]        M_icode;
   logic              M_cnd;
   logic [ADDR_W-1:0] M_valA;
   logic [3:0]        W_icode;
   logic [ADDR_W-1:0] W_valM;
   logic [ADDR_W-1:0] F_predPC;
   logic [1:0]        fsm_state;

   fetch_pc_ctrl_if #(.ADDR_W(ADDR_W)) fbus ();

   fetch_pc_ctrl #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .F_stall   (F_stall),
      .fbus      (fbus.master),
      .M_icode   (M_icode),
      .M_cnd     (M_cnd),
      .M_valA    (M_valA),
      .W_icode   (W_icode),
      .W_valM    (W_valM),
      .F_predPC  (F_predPC),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   typedef struct {
      string             name;
      logic [ADDR_W-1:0] pc;
      logic              valid;
      logic [ADDR_W-1:0] pred;
      logic [1:0]        st;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   failed = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, " f_pc"},      fbus.f_pc,             e.pc);
            check({e.name, " f_valid"},   64'(fbus.f_valid),     64'(e.valid));
            check({e.name, " F_predPC"},  F_predPC,              e.pred);
            check({e.name, " fsm_state"}, 64'(fsm_state),        64'(e.st));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   // Fetch unit modes: fetching freely, waiting for a ret to reach W,
   // or stopped after halt/invalid.
   typedef enum int {FETCHING, AWAIT_RET, STOPPED} mode_t;

   mode_t             m_mode = FETCHING;
   logic [ADDR_W-1:0] m_pred = '0;

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // Called at posedge+1 with this cycle's inputs applied.
   task automatic step(input string name);
      exp_t              e;
      logic              mis, rd, ok;
      logic [ADDR_W-1:0] pc;
      if (!rst_n) begin
         m_pred = '0;
         m_mode = FETCHING;
      end
      mis = (M_icode == 4'h7) && !M_cnd;
      rd  = (W_icode == 4'h9);
      case (m_mode)
         FETCHING:  ok = 1'b1;
         AWAIT_RET: ok = mis || rd;
         default:   ok = mis;
      endcase
      if (mis)                           pc = M_valA;
      else if (m_mode == AWAIT_RET && rd) pc = W_valM;
      else                               pc = m_pred;

      e.name  = name;
      e.pc    = pc;
      e.valid = ok;
      e.pred  = m_pred;
      case (m_mode)
         FETCHING:  e.st = 2'b00;
         AWAIT_RET: e.st = 2'b01;
         default:   e.st = 2'b10;
      endcase
      sb.push_back(e);

      if (rst_n) begin
         if (F_stall) begin
            m_pred = pc;
            if (mis || (m_mode == AWAIT_RET && rd)) m_mode = FETCHING;
         end else if (ok) begin
            m_pred = (fbus.f_icode == 4'h7 || fbus.f_icode == 4'h8) ? fbus.f_valC : fbus.f_valP;
            if (fbus.f_halt)                m_mode = STOPPED;
            else if (fbus.f_icode == 4'h9)  m_mode = AWAIT_RET;
            else                            m_mode = FETCHING;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      F_stall      = 1'b0;
      M_icode      = 4'h0;
      M_cnd        = 1'b1;
      M_valA       = '0;
      W_icode      = 4'h0;
      W_valM       = '0;
      fbus.f_icode = 4'h1;
      fbus.f_valC  = '0;
      fbus.f_valP  = '0;
      fbus.f_halt  = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : driver
      logic [3:0] icodes [8];
      icodes = '{4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};

      idle();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      step("reset_hold");
      rst_n = 1'b1;

      // nop then jXX: predictions valP then valC
      fbus.f_icode = 4'h1; fbus.f_valP = 64'h1;
      step("nop_fetch");
      fbus.f_icode = 4'h7; fbus.f_valC = 64'h40; fbus.f_valP = 64'h0A;
      step("jxx_fetch");

      // mispredict redirects fetch to 0x0A in the same cycle
      idle();
      M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h0A;
      fbus.f_icode = 4'h1; fbus.f_valP = 64'h0C;
      step("mispred_redirect");
      idle();
      step("after_mispred");

      // ret fetched: three bubble cycles, then the return address
      fbus.f_icode = 4'h9; fbus.f_valP = 64'h0E;
      step("ret_fetch");
      idle();
      for (int i = 0; i < 3; i++) step("ret_wait_bubble");
      W_icode = 4'h9; W_valM = 64'h100;
      fbus.f_icode = 4'h1; fbus.f_valP = 64'h102;
      step("ret_done");
      idle();

      // retdone while stalled: redirect captured into F_predPC
      fbus.f_icode = 4'h9; fbus.f_valP = 64'h104;
      step("ret_fetch2");
      idle();
      step("ret_wait2");
      W_icode = 4'h9; W_valM = 64'h100; F_stall = 1'b1;
      step("ret_done_stalled");
      idle();
      fbus.f_icode = 4'h1; fbus.f_valP = 64'h101;
      step("fetch_after_stall");

      // halt: ten bubble cycles (a ret in W does not wake it), then mispred
      idle();
      fbus.f_icode = 4'h0; fbus.f_halt = 1'b1;
      step("halt_fetch");
      idle();
      for (int i = 0; i < 10; i++) begin
         W_icode = (i == 4) ? 4'h9 : 4'h0;
         W_valM  = 64'h300;
         step("halted_bubble");
      end
      idle();
      M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h20;
      fbus.f_icode = 4'h1; fbus.f_valP = 64'h21;
      step("halt_mispred");

      // reset pulse while waiting on a ret
      idle();
      fbus.f_icode = 4'h9;
      step("ret_before_reset");
      idle();
      rst_n = 1'b0;
      step("reset_mid_run");
      rst_n = 1'b1;
      fbus.f_valP = 64'h2;
      step("after_reset");

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst_n        = ($urandom_range(0, 199) != 0);
         F_stall      = ($urandom_range(0, 4) == 0);
         M_icode      = ($urandom_range(0, 7) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
         M_cnd        = ($urandom_range(0, 1) == 1);
         M_valA       = rnd64();
         W_icode      = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
         W_valM       = rnd64();
         fbus.f_icode = icodes[$urandom_range(0, 7)];
         fbus.f_valC  = rnd64();
         fbus.f_valP  = rnd64();
         fbus.f_halt  = ($urandom_range(0, 19) == 0);
         step("random");
      end

      rst_n = 1'b1;
      idle();
      @(negedge clk);
      #1;
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
